// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit two-flop synchroniser followed by a counter-based bounce filter.
// Macro DEBOUNCE_EDGE_EN builds the registered sw_rise/sw_fall strobes; when undefined they are tied low.
module switch_debouncer #(
   parameter int unsigned WIDTH           = 8,
   parameter logic [23:0] DEBOUNCE_CYCLES = 24'd100_000,
   parameter int unsigned CNT_W           = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_level,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 24'd1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_level;
   logic [CNT_W-1:0] r_cnt       [WIDTH];
   state_t           r_state     [WIDTH];

   logic [WIDTH-1:0] w_level_nxt;
   logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];
   state_t           w_state_nxt [WIDTH];

   // synchroniser, per-channel state, counters and debounced level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_level <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i]   <= '0;
            r_state[i] <= ST_IDLE;
         end
      end else begin
         r_sync1 <= sw_in;
         r_sync2 <= r_sync1;
         r_level <= w_level_nxt;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i]   <= w_cnt_nxt[i];
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // next-state logic; the state register is kept equal to (sync2 != level) by looking one edge ahead
   always_comb begin
      w_level_nxt = r_level;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_nxt[i]   = '0;
         w_state_nxt[i] = ST_IDLE;
         case (r_state[i])
            ST_IDLE: begin
               w_cnt_nxt[i] = '0;
            end
            ST_PENDING: begin
               if (r_cnt[i] == LP_CNT_LAST) begin
                  w_level_nxt[i] = r_sync2[i];
                  w_cnt_nxt[i]   = '0;
               end else begin
                  w_cnt_nxt[i]   = r_cnt[i] + LP_CNT_ONE;
               end
            end
            default: begin
               w_cnt_nxt[i] = '0;
            end
         endcase
         if (r_sync1[i] != w_level_nxt[i]) begin
            w_state_nxt[i] = ST_PENDING;
         end else begin
            w_state_nxt[i] = ST_IDLE;
         end
      end
   end

   assign sw_level = r_level;

`ifdef DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;

   // strobes mark the cycle in which the debounced level first shows its new value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_rise <= w_level_nxt & ~r_level;
         r_fall <= ~w_level_nxt & r_level;
      end
   end

   assign sw_rise = r_rise;
   assign sw_fall = r_fall;
`else
   assign sw_rise = '0;
   assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (DEBOUNCE_CYCLES=4): expected outputs are queued with their
// due cycle as stimulus is driven, then popped and checked 1 time unit after each rising edge.
module tb_switch_debouncer;

   localparam int unsigned WIDTH = 8;
`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] sw_in;
   logic [WIDTH-1:0] sw_level;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;

   always #5 clk = ~clk;

   switch_debouncer #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (24'd4),
      .CNT_W           (24)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sw_in    (sw_in),
      .sw_level (sw_level),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall)
   );

   typedef struct {
      int         due;
      string      tag;
      logic [7:0] lvl;
      logic [7:0] rise;
      logic [7:0] fall;
   } exp_t;

   exp_t q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   t0;

   task automatic cmp(input string tag, input string what, input logic [7:0] got, input logic [7:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s.%s cyc=%0d observed=%h expected=%h", tag, what, cyc, got, want);
      end
   endtask

   task automatic expect_at(input string tag, input int due, input logic [7:0] l,
                            input logic [7:0] r, input logic [7:0] f);
      exp_t e;
      e.due  = due;
      e.tag  = tag;
      e.lvl  = l;
      e.rise = EDGE_EN ? r : 8'h00;
      e.fall = EDGE_EN ? f : 8'h00;
      q.push_back(e);
   endtask

   // quiet interval: level constant, no strobes
   task automatic expect_span(input string tag, input int from, input int to, input logic [7:0] l);
      for (int c = from; c <= to; c++) begin
         expect_at(tag, c, l, 8'h00, 8'h00);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         cyc++;
         #1;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
               cmp(q[i].tag, "level", sw_level, q[i].lvl);
               cmp(q[i].tag, "rise",  sw_rise,  q[i].rise);
               cmp(q[i].tag, "fall",  sw_fall,  q[i].fall);
               q.delete(i);
            end
         end
      end
   endtask

   initial begin
      // 1: reset with all switches held high, then full-latency rise
      sw_in = 8'hFF;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      cmp("s1_async", "level", sw_level, 8'h00);
      cmp("s1_async", "rise",  sw_rise,  8'h00);
      cmp("s1_async", "fall",  sw_fall,  8'h00);
      expect_span("s1_in_reset", cyc + 1, cyc + 3, 8'h00);
      tick(3);
      reset = 1'b0;
      t0 = cyc;
      expect_span("s1_wait", t0 + 1, t0 + 5, 8'h00);
      expect_at("s1_edge", t0 + 6, 8'hFF, 8'hFF, 8'h00);
      expect_span("s1_after", t0 + 7, t0 + 8, 8'hFF);
      tick(8);

      // all switches released: every channel falls together
      sw_in = 8'h00;
      t0 = cyc;
      expect_span("all_fall_wait", t0 + 1, t0 + 5, 8'hFF);
      expect_at("all_fall_edge", t0 + 6, 8'h00, 8'h00, 8'hFF);
      expect_span("all_fall_after", t0 + 7, t0 + 8, 8'h00);
      tick(8);

      // 2: bounce rejection on channel 0 with 1, 2 and 3 cycle pulses
      t0 = cyc;
      expect_span("s2_bounce", t0 + 1, t0 + 20, 8'h00);
      sw_in = 8'h01; tick(1);
      sw_in = 8'h00; tick(4);
      sw_in = 8'h01; tick(2);
      sw_in = 8'h00; tick(4);
      sw_in = 8'h01; tick(3);
      sw_in = 8'h00; tick(6);
      sw_in = 8'h01;
      t0 = cyc;
      expect_span("s2_hold_wait", t0 + 1, t0 + 5, 8'h00);
      expect_at("s2_hold_edge", t0 + 6, 8'h01, 8'h01, 8'h00);
      expect_span("s2_hold_after", t0 + 7, t0 + 10, 8'h01);
      tick(10);

      // 3: raise channel 3, then release it and expect one fall strobe
      sw_in = 8'h09;
      t0 = cyc;
      expect_span("s3_rise_wait", t0 + 1, t0 + 5, 8'h01);
      expect_at("s3_rise_edge", t0 + 6, 8'h09, 8'h08, 8'h00);
      expect_span("s3_rise_after", t0 + 7, t0 + 8, 8'h09);
      tick(8);
      sw_in = 8'h01;
      t0 = cyc;
      expect_span("s3_fall_wait", t0 + 1, t0 + 5, 8'h09);
      expect_at("s3_fall_edge", t0 + 6, 8'h01, 8'h00, 8'h08);
      expect_span("s3_fall_after", t0 + 7, t0 + 8, 8'h01);
      tick(8);

      // 4: channels 1 and 6 together; channel 6 bounces low for one cycle after two cycles
      t0 = cyc;
      expect_span("s4_wait", t0 + 1, t0 + 5, 8'h01);
      expect_at("s4_ch1", t0 + 6, 8'h03, 8'h02, 8'h00);
      expect_span("s4_mid", t0 + 7, t0 + 8, 8'h03);
      expect_at("s4_ch6", t0 + 9, 8'h43, 8'h40, 8'h00);
      expect_span("s4_after", t0 + 10, t0 + 11, 8'h43);
      sw_in = 8'h43; tick(2);
      sw_in = 8'h03; tick(1);
      sw_in = 8'h43; tick(8);

      // 5: reset while channel 2 is pending with cnt=2
      sw_in = 8'h47;
      t0 = cyc;
      expect_span("s5_pending", t0 + 1, t0 + 4, 8'h43);
      tick(4);
      #2 reset = 1'b1;
      #1;
      cmp("s5_async", "level", sw_level, 8'h00);
      cmp("s5_async", "rise",  sw_rise,  8'h00);
      cmp("s5_async", "fall",  sw_fall,  8'h00);
      expect_span("s5_in_reset", cyc + 1, cyc + 2, 8'h00);
      tick(2);
      reset = 1'b0;
      t0 = cyc;
      expect_span("s5_wait", t0 + 1, t0 + 5, 8'h00);
      expect_at("s5_edge", t0 + 6, 8'h47, 8'h47, 8'h00);
      expect_span("s5_after", t0 + 7, t0 + 8, 8'h47);
      tick(8);

      n_tests++;
      assert (q.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain observed=%0d expected=0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
